// File: rtl/inst_fetch.sv
// Instruction fetch stage for the 16-bit THCO-MIPS pipeline: PC, req/ack memory reads, stall and redirect.
// Optional one-entry skid buffer enabled by defining INST_FETCH_SKID_EN.
module inst_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_OP   = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] flush_pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] op,
  output logic        op_valid,
  output logic [15:0] op_pc
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_REDIR} state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_op;
  logic [15:0] r_op_pc;
  logic        r_op_valid;
  logic        w_req;
  logic        w_hs;

`ifdef INST_FETCH_SKID_EN
  logic        r_full;
  logic [15:0] r_buf;
  logic [15:0] r_buf_pc;

  // The request no longer depends on stall: a stalled ack lands in the buffer.
  assign w_req = (r_state == S_FETCH) && !r_full;
`else
  assign w_req = (r_state == S_FETCH) && !stall;
`endif

  assign w_hs     = w_req && mem_ack;
  assign mem_req  = w_req;
  assign mem_addr = (r_state == S_IDLE) ? 16'h0000 : r_pc;
  assign op       = r_op;
  assign op_valid = r_op_valid;
  assign op_pc    = r_op_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_op       <= NOP_OP;
      r_op_valid <= 1'b0;
      r_op_pc    <= 16'h0000;
`ifdef INST_FETCH_SKID_EN
      r_full     <= 1'b0;
`endif
    end else if (r_state == S_IDLE) begin
      if (flush) r_pc <= flush_pc;
      r_state <= S_FETCH;
    end else if (flush) begin
      // Redirect beats stall and any same-cycle ack; ack data is dropped.
      r_pc       <= flush_pc;
      r_op       <= NOP_OP;
      r_op_valid <= 1'b0;
      r_state    <= S_REDIR;
`ifdef INST_FETCH_SKID_EN
      r_full     <= 1'b0;
`endif
    end else if (r_state == S_REDIR) begin
      r_state <= S_FETCH;
`ifdef INST_FETCH_SKID_EN
    end else if (stall) begin
      if (w_hs) begin
        r_full <= 1'b1;
        r_pc   <= r_pc + 16'h0001;
      end
    end else if (r_full) begin
      r_op       <= r_buf;
      r_op_pc    <= r_buf_pc;
      r_op_valid <= 1'b1;
      r_full     <= 1'b0;
`else
    end else if (stall) begin
      r_state <= S_FETCH;
`endif
    end else if (w_hs) begin
      r_op       <= mem_rdata;
      r_op_valid <= 1'b1;
      r_op_pc    <= r_pc;
      r_pc       <= r_pc + 16'h0001;
    end else begin
      r_op       <= NOP_OP;
      r_op_valid <= 1'b0;
    end
  end

`ifdef INST_FETCH_SKID_EN
  always_ff @(posedge clk) begin
    if (stall && w_hs && !flush) begin
      r_buf    <= mem_rdata;
      r_buf_pc <= r_pc;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, async reset check, and randomized run against a reference model.
module tb_inst_fetch;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] flush_pc = 16'h0000;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] op;
  logic        op_valid;
  logic [15:0] op_pc;

  int n_vec = 0;
  int n_err = 0;

  inst_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .op(op), .op_valid(op_valid), .op_pc(op_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [15:0] fpc;
    logic        ack;
    logic [15:0] rdata;
    logic        ereq;
    logic [15:0] eaddr;
    logic [15:0] eop;
    logic        ev;
    logic [15:0] eoppc;
  } vec_t;

  vec_t tbl[17];

  // Reference model: what the fetch stage should present, derived from the
  // architectural rules (started / redirect bubble / pc / last delivered op).
  bit          m_started;
  bit          m_redir;
  logic [15:0] m_pc;
  logic [15:0] m_op;
  logic        m_v;
  logic [15:0] m_oppc;

  task automatic model_reset();
    m_started = 0; m_redir = 0; m_pc = 16'h0000;
    m_op = NOP; m_v = 1'b0; m_oppc = 16'h0000;
  endtask

  function automatic logic model_req(input logic s);
    return m_started && !m_redir && !s;
  endfunction

  task automatic model_edge(input logic s, input logic f, input logic [15:0] fpc,
                            input logic a, input logic [15:0] d);
    if (!m_started) begin
      if (f) m_pc = fpc;
      m_started = 1;
    end else if (f) begin
      m_pc = fpc; m_op = NOP; m_v = 1'b0; m_redir = 1;
    end else if (m_redir) begin
      m_redir = 0;
    end else if (!s) begin
      if (a) begin
        m_op = d; m_v = 1'b1; m_oppc = m_pc; m_pc = 16'((32'(m_pc) + 1) % 65536);
      end else begin
        m_op = NOP; m_v = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input logic ereq, input logic [15:0] eaddr, input logic [15:0] eop,
                         input logic ev, input logic [15:0] eoppc);
    chk("mem_req", {15'd0, mem_req}, {15'd0, ereq});
    chk("mem_addr", mem_addr, eaddr);
    chk("op", op, eop);
    chk("op_valid", {15'd0, op_valid}, {15'd0, ev});
    chk("op_pc", op_pc, eoppc);
  endtask

  // One model-checked cycle: drive, check at negedge, advance model at posedge.
  task automatic mcycle(input logic s, input logic f, input logic [15:0] fpc,
                        input logic a, input logic [15:0] d);
    stall = s; flush = f; flush_pc = fpc; mem_ack = a; mem_rdata = d;
    @(negedge clk);
    chk_all(model_req(s), m_started ? m_pc : 16'h0000, m_op, m_v, m_oppc);
    @(posedge clk);
    model_edge(s, f, fpc, a && model_req(s), d);
    #1;
  endtask

  initial begin
    int cnt;
    logic a;
    logic [15:0] fpc;
    tbl[0]  = '{0, 0, 16'h0000, 1, 16'h4901, 0, 16'h0000, NOP,      0, 16'h0000};
    tbl[1]  = '{0, 0, 16'h0000, 1, 16'h4901, 1, 16'h0000, NOP,      0, 16'h0000};
    tbl[2]  = '{0, 0, 16'h0000, 1, 16'h4902, 1, 16'h0001, 16'h4901, 1, 16'h0000};
    tbl[3]  = '{0, 0, 16'h0000, 1, 16'h4903, 1, 16'h0002, 16'h4902, 1, 16'h0001};
    tbl[4]  = '{0, 0, 16'h0000, 0, 16'h4904, 1, 16'h0003, 16'h4903, 1, 16'h0002};
    tbl[5]  = '{0, 0, 16'h0000, 1, 16'h4904, 1, 16'h0003, NOP,      0, 16'h0002};
    tbl[6]  = '{1, 0, 16'h0000, 1, 16'hDEAD, 0, 16'h0004, 16'h4904, 1, 16'h0003};
    tbl[7]  = '{1, 0, 16'h0000, 1, 16'hBEEF, 0, 16'h0004, 16'h4904, 1, 16'h0003};
    tbl[8]  = '{0, 1, 16'h0040, 1, 16'h1234, 1, 16'h0004, 16'h4904, 1, 16'h0003};
    tbl[9]  = '{0, 0, 16'h0000, 1, 16'h7777, 0, 16'h0040, NOP,      0, 16'h0003};
    tbl[10] = '{0, 0, 16'h0000, 1, 16'h5555, 1, 16'h0040, NOP,      0, 16'h0003};
    tbl[11] = '{1, 1, 16'hFFFF, 1, 16'h6666, 0, 16'h0041, 16'h5555, 1, 16'h0040};
    tbl[12] = '{0, 0, 16'h0000, 1, 16'h8888, 0, 16'hFFFF, NOP,      0, 16'h0040};
    tbl[13] = '{0, 0, 16'h0000, 1, 16'h0101, 1, 16'hFFFF, NOP,      0, 16'h0040};
    tbl[14] = '{0, 0, 16'h0000, 1, 16'h0202, 1, 16'h0000, 16'h0101, 1, 16'hFFFF};
    tbl[15] = '{0, 0, 16'h0000, 0, 16'h0303, 1, 16'h0001, 16'h0202, 1, 16'h0000};
    tbl[16] = '{0, 0, 16'h0000, 0, 16'h0404, 1, 16'h0001, NOP,      0, 16'h0000};

    // Reset state while held in reset.
    #12;
    chk_all(1'b0, 16'h0000, NOP, 1'b0, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      stall = tbl[i].stall; flush = tbl[i].flush; flush_pc = tbl[i].fpc;
      mem_ack = tbl[i].ack; mem_rdata = tbl[i].rdata;
      @(negedge clk);
      chk_all(tbl[i].ereq, tbl[i].eaddr, tbl[i].eop, tbl[i].ev, tbl[i].eoppc);
      @(posedge clk); #1;
    end

    // Async reset during an outstanding request: no clock edge before the check.
    stall = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    #2 rst = 1'b0;
    #1 chk_all(1'b0, 16'h0000, NOP, 1'b0, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();

    // Memory answering on the third cycle of each request.
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      a = 1'b0;
      if (model_req(1'b0)) begin
        cnt++;
        if (cnt == 3) begin a = 1'b1; cnt = 0; end
      end
      mcycle(1'b0, 1'b0, 16'h0000, a, 16'h4901 + m_pc);
    end

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      fpc = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom);
      mcycle($urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0, fpc,
             $urandom_range(0, 9) < 6, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
